gfx256_fragment: RTL
====================

// Module: gfx256_fragment
// PURPOSE
//  Fragment stage directly downstream of the clip/z-test stage. Accepts one surviving pixel at a time
//  (x,y,z,u,v,alpha,flat color) and, when texturing is enabled, fetches the texel at (u,v) over the
//  shared wishbone read master. It then applies colorkey discard and forwards the pixel to the blender.
//  Uses the same write/ack pixel handshake on both sides as the rest of the gfx256 pipeline.
// PARAMETERS
//  point_width  16  width of x/y/z/u/v coordinates
// PORTS
//  clk_i               in   1     clock
//  rst_i               in   1     synchronous, active-high reset
//  texture_enable_i    in   1     1 = color from texture, 0 = pass color_i
//  colorkey_enable_i   in   1     1 = discard texels equal to colorkey_i
//  colorkey_i          in   32    colorkey, compared after zero-extension
//  color_depth_i       in   2     0=8bpp, 1=16bpp, 2/3=32bpp
//  tex_base_i          in   27    [31:5] texture base, 32-byte aligned
//  tex_size_x_i        in   pw    texture width in texels (>=1)
//  tex_size_y_i        in   pw    texture height in texels (>=1)
//  pixel_x_i/y_i/z_i   in   pw    pixel from clip stage
//  u_i, v_i            in   pw    texture coordinates (unsigned texels)
//  a_i                 in   8     alpha
//  color_i             in   32    flat/interpolated color
//  write_i             in   1     pixel valid from clip stage (held until ack_o)
//  ack_o               out  1     1-cycle pulse: pixel consumed (written or discarded)
//  tex_request_o       out  1     read request to wishbone reader
//  tex_addr_o          out  27    [31:5] 32-byte line address
//  tex_data_i          in   256   returned line
//  tex_ack_i           in   1     read complete, tex_data_i valid this cycle
//  wbm_busy_i          in   1     reader busy; do not raise a new request
//  pixel_x_o/y_o/z_o   out  pw    pixel to blender
//  a_o                 out  8     alpha to blender
//  color_o             out  32    final color to blender
//  write_o             out  1     1-cycle pulse: pixel valid to blender
//  ack_i               in   1     blender done with pixel
// BEHAVIOUR
//  Reset: state=IDLE; ack_o, write_o, tex_request_o=0; all data outputs and tex_addr_o=0.
//  IDLE: on write_i, latch all pixel inputs. Go to ADDR if texture_enable_i, else go to WRITE
//   with color_o=color_i and write_o=1 the next cycle.
//  ADDR (1 cycle): uc = min(u, tex_size_x-1), vc = min(v, tex_size_y-1). off = vc*tex_size_x + uc (32b).
//   boff = off<<{0,1,2} per depth. tex_addr_o = tex_base_i + boff[31:5] (27b, wraps mod 2^27).
//   lane = boff[4:0] is registered. Then go to TREQ.
//  TREQ: tex_request_o rises when ~wbm_busy_i and stays high until tex_ack_i. On tex_ack_i: drop the
//   request and extract the texel, zero-extended to 32:
//    8bpp: data[lane*8+:8]; 16bpp: data[lane[4:1]*16+:16]; 32bpp: data[lane[4:2]*32+:32].
//   If colorkey_enable_i and texel==colorkey_i: ack_o=1 next cycle, no write_o, go to IDLE.
//   Else color_o=texel, write_o=1 next cycle, go to WRITE.
//  WRITE: write_o is high for exactly one cycle. Hold outputs stable until ack_i, then pulse ack_o
//   for 1 cycle next cycle and go to IDLE.
//  Upstream write_i is ignored outside IDLE and on the cycle after ack_o (write_i may still be high there).
//  Minimum no-texture latency: write_i -> write_o is 1 cycle. ack_i -> ack_o is 1 cycle.
//  tex_ack_i arriving in the same cycle the request rises is accepted. tex_ack_i outside TREQ is ignored.
//  Reset mid-operation: immediate return to IDLE, request dropped, no ack_o or write_o emitted.
//  Config inputs are sampled when used and must be stable while a pixel is in flight.
// TESTING
//  tex off, color_i=32'h11223344, x=5,y=7 -> write_o 1 cycle later, color_o=11223344. ack_i -> ack_o next cycle.
//  16bpp, base=0x100, size_x=64, u=3, v=2 -> tex_addr_o=0x108, lane=6. data word 3=16'hBEEF -> color_o=0000BEEF.
//  u=200, v=0 with size_x=64, 32bpp -> u clamped to 63: tex_addr_o=base+7, word 7 selected.
//  colorkey on, key=0x000000AA, 8bpp texel 0xAA -> ack_o pulse, write_o never asserted.
//  wbm_busy_i held 10 cycles -> tex_request_o stays 0, rises the cycle after busy drops.
//  rst_i asserted in TREQ -> tex_request_o=0 next cycle. A new pixel is then processed normally.

Source files
------------

// File: rtl/gfx256_fragment.sv
// gfx256 fragment stage: takes one pixel from the clip/z-test stage. When texturing
// is on it fetches the texel line over the shared wishbone reader, applies colorkey
// discard, and forwards the pixel to the blender.
// Both sides use a write/ack pixel handshake. Upstream write_i is held until ack_o
// pulses, and the stage accepts it only in IDLE when ack_o is not high. Downstream
// write_o pulses for one cycle, and the outputs stay stable until the blender
// returns ack_i.
module gfx256_fragment #(
  parameter int point_width = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   texture_enable_i,
  input  logic                   colorkey_enable_i,
  input  logic [31:0]            colorkey_i,
  input  logic [1:0]             color_depth_i,
  input  logic [26:0]            tex_base_i,
  input  logic [point_width-1:0] tex_size_x_i,
  input  logic [point_width-1:0] tex_size_y_i,
  input  logic [point_width-1:0] pixel_x_i,
  input  logic [point_width-1:0] pixel_y_i,
  input  logic [point_width-1:0] pixel_z_i,
  input  logic [point_width-1:0] u_i,
  input  logic [point_width-1:0] v_i,
  input  logic [7:0]             a_i,
  input  logic [31:0]            color_i,
  input  logic                   write_i,
  output logic                   ack_o,
  output logic                   tex_request_o,
  output logic [26:0]            tex_addr_o,
  input  logic [255:0]           tex_data_i,
  input  logic                   tex_ack_i,
  input  logic                   wbm_busy_i,
  output logic [point_width-1:0] pixel_x_o,
  output logic [point_width-1:0] pixel_y_o,
  output logic [point_width-1:0] pixel_z_o,
  output logic [7:0]             a_o,
  output logic [31:0]            color_o,
  output logic                   write_o,
  input  logic                   ack_i,
  output logic [2:0]             dbg_state_o
);

  localparam int PW = point_width;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_TREQ  = 3'd2,
    S_WRITE = 3'd3
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   u_q, v_q;
  logic [4:0]      lane_q;
  logic            ack_q, write_q, req_q;
  logic [26:0]     addr_q;
  logic [PW-1:0]   x_q, y_q, z_q;
  logic [7:0]      a_q;
  logic [31:0]     color_q;

  logic [PW-1:0]   sx_m1, sy_m1, uc, vc;
  logic [31:0]     off, boff;
  logic [26:0]     addr_d;
  logic [4:0]      lane_d;
  logic [31:0]     texel;
  logic            key_hit;

  // Texel address: clamp (u,v) into the texture, linearise, scale by bytes per texel
  always_comb begin
    sx_m1  = tex_size_x_i - 1'b1;
    sy_m1  = tex_size_y_i - 1'b1;
    uc     = (u_q > sx_m1) ? sx_m1 : u_q;
    vc     = (v_q > sy_m1) ? sy_m1 : v_q;
    off    = ({{(32-PW){1'b0}}, vc} * {{(32-PW){1'b0}}, tex_size_x_i})
           + {{(32-PW){1'b0}}, uc};
    case (color_depth_i)
      2'd0:    boff = off;
      2'd1:    boff = {off[30:0], 1'b0};
      default: boff = {off[29:0], 2'b00};
    endcase
    addr_d = tex_base_i + boff[31:5];
    lane_d = boff[4:0];
  end

  // Texel extraction from the returned 256-bit line, zero-extended to 32 bits
  always_comb begin
    case (color_depth_i)
      2'd0:    texel = {24'b0, tex_data_i[{lane_q, 3'b000} +: 8]};
      2'd1:    texel = {16'b0, tex_data_i[{lane_q[4:1], 4'b0000} +: 16]};
      default: texel = tex_data_i[{lane_q[4:2], 5'b00000} +: 32];
    endcase
    key_hit = colorkey_enable_i && (texel == colorkey_i);
  end

  // Main control FSM with registered handshake and data outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      u_q     <= '0;
      v_q     <= '0;
      lane_q  <= '0;
      ack_q   <= 1'b0;
      write_q <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      a_q     <= '0;
      color_q <= '0;
    end else begin
      ack_q   <= 1'b0;
      write_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // ack_q high means write_i is the stale request just acknowledged
          if (write_i && !ack_q) begin
            x_q <= pixel_x_i;
            y_q <= pixel_y_i;
            z_q <= pixel_z_i;
            a_q <= a_i;
            u_q <= u_i;
            v_q <= v_i;
            if (texture_enable_i) begin
              state_q <= S_ADDR;
            end else begin
              color_q <= color_i;
              write_q <= 1'b1;
              state_q <= S_WRITE;
            end
          end
        end
        S_ADDR: begin
          addr_q  <= addr_d;
          lane_q  <= lane_d;
          state_q <= S_TREQ;
        end
        S_TREQ: begin
          if (req_q && tex_ack_i) begin
            req_q <= 1'b0;
            if (key_hit) begin
              ack_q   <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              color_q <= texel;
              write_q <= 1'b1;
              state_q <= S_WRITE;
            end
          end else if (!req_q && !wbm_busy_i) begin
            req_q <= 1'b1;
          end
        end
        S_WRITE: begin
          if (ack_i) begin
            ack_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack_o         = ack_q;
  assign write_o       = write_q;
  assign tex_request_o = req_q;
  assign tex_addr_o    = addr_q;
  assign pixel_x_o     = x_q;
  assign pixel_y_o     = y_q;
  assign pixel_z_o     = z_q;
  assign a_o           = a_q;
  assign color_o       = color_q;
  assign dbg_state_o   = state_q;

endmodule
